sdram_arbiter: RTL and testbench

Top-level command arbiter of the SDRAM controller. It owns the single SDRAM command/address/bank bus and grants it to exactly one of four sub-sequencers at a time:

- power-up init
- auto-refresh
- burst write
- burst read

Refresh has absolute priority. Write and read requests are served round-robin. Sub-sequencers start on a one-cycle enable pulse and return the bus with a one-cycle end pulse.

---
 rtl/sdram_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: grants the single cmd/addr/bank bus to init, refresh,
// write or read sequencer. Refresh wins outright; write/read alternate when both wait.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int BANK_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic [3:0]            init_cmd,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic                  ref_rq,
    input  logic                  ref_end,
    input  logic [3:0]            ref_cmd,
    input  logic [ADDR_WIDTH-1:0] ref_addr,
    input  logic                  wr_rq,
    input  logic                  wr_end,
    input  logic [3:0]            wr_cmd,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BANK_WIDTH-1:0] wr_bank,
    input  logic                  rd_rq,
    input  logic                  rd_end,
    input  logic [3:0]            rd_cmd,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [BANK_WIDTH-1:0] rd_bank,
    output logic                  ref_en,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [3:0]            sdram_cmd,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [BANK_WIDTH-1:0] sdram_bank,
    output logic                  busy
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t state, next_state;
    logic   last_rd;    // 1: the most recently completed burst was a read

    // State register; enables are registered off the ARBIT decision so that
    // they rise together with the new state and never depend combinationally on *_rq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_INIT;
            ref_en <= 1'b0;
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
        end else begin
            state  <= next_state;
            ref_en <= (state == S_ARBIT) && (next_state == S_AREF);
            wr_en  <= (state == S_ARBIT) && (next_state == S_WRITE);
            rd_en  <= (state == S_ARBIT) && (next_state == S_READ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_rd <= 1'b1;
        else if (state == S_WRITE && wr_end)
            last_rd <= 1'b0;
        else if (state == S_READ && rd_end)
            last_rd <= 1'b1;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:  if (init_end) next_state = S_ARBIT;
            S_ARBIT: begin
                if (ref_rq)
                    next_state = S_AREF;
                else if (wr_rq && rd_rq)
                    next_state = last_rd ? S_WRITE : S_READ;
                else if (wr_rq)
                    next_state = S_WRITE;
                else if (rd_rq)
                    next_state = S_READ;
            end
            S_AREF:  if (ref_end) next_state = S_ARBIT;
            S_WRITE: if (wr_end)  next_state = S_ARBIT;
            S_READ:  if (rd_end)  next_state = S_ARBIT;
            default: next_state = S_INIT;
        endcase
    end

    // Bus mux follows the state register; reset forces NOP without waiting for a clock.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        busy       = 1'b0;
        case (state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
                busy       = 1'b1;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
                busy       = 1'b1;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
                busy       = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            sdram_cmd  = CMD_NOP;
            sdram_addr = '0;
            sdram_bank = '0;
            busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant order is scoreboarded by a negedge monitor,
// bus mux / timing / reset checked inline.
module tb_sdram_arbiter;

    localparam int AW = 12;
    localparam int BW = 2;
    localparam int G_REF = 0;
    localparam int G_WR  = 1;
    localparam int G_RD  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_end;
    logic [3:0]    init_cmd;
    logic [AW-1:0] init_addr;
    logic          ref_rq, ref_end;
    logic [3:0]    ref_cmd;
    logic [AW-1:0] ref_addr;
    logic          wr_rq, wr_end;
    logic [3:0]    wr_cmd;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_bank;
    logic          rd_rq, rd_end;
    logic [3:0]    rd_cmd;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_bank;
    logic          ref_en, wr_en, rd_en;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_bank;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;
    int sb[$];
    int mon_n_en;
    int mon_code;
    int mon_prev = 0;
    int exp_g;

    sdram_arbiter #(.ADDR_WIDTH(AW), .BANK_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_rq(ref_rq), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_rq(wr_rq), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_rq(rd_rq), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd"},  32'(sdram_cmd), 32'(4'b0111));
        chk({tag, "_addr"}, 32'(sdram_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ens"},  32'({ref_en, wr_en, rd_en}), 32'd0);
    endtask

    task automatic chk_grant(input int who);
        case (who)
            G_REF: begin
                chk("ref_en_hi", 32'({ref_en, wr_en, rd_en}), 32'b100);
                chk("ref_mux_cmd", 32'(sdram_cmd), 32'(ref_cmd));
                chk("ref_mux_addr", 32'(sdram_addr), 32'(ref_addr));
                chk("ref_mux_bank", 32'(sdram_bank), 32'd0);
            end
            G_WR: begin
                chk("wr_en_hi", 32'({ref_en, wr_en, rd_en}), 32'b010);
                chk("wr_mux_cmd", 32'(sdram_cmd), 32'(wr_cmd));
                chk("wr_mux_addr", 32'(sdram_addr), 32'(wr_addr));
                chk("wr_mux_bank", 32'(sdram_bank), 32'(wr_bank));
            end
            default: begin
                chk("rd_en_hi", 32'({ref_en, wr_en, rd_en}), 32'b001);
                chk("rd_mux_cmd", 32'(sdram_cmd), 32'(rd_cmd));
                chk("rd_mux_addr", 32'(sdram_addr), 32'(rd_addr));
                chk("rd_mux_bank", 32'(sdram_bank), 32'(rd_bank));
            end
        endcase
        chk("grant_busy", 32'(busy), 32'd1);
    endtask

    // Called in the grant cycle: hold the bus, pulse the owner's end, expect one idle
    // ARBIT cycle, then the next grant.
    task automatic finish_and_grant(input int owner, input int next, input int hold);
        repeat (hold) tick;
        case (owner)
            G_REF:   ref_end = 1'b1;
            G_WR:    wr_end  = 1'b1;
            default: rd_end  = 1'b1;
        endcase
        tick;
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        chk_idle("gap");
        sb.push_back(next);
        tick;
        chk_grant(next);
    endtask

    // Grant scoreboard: every enable pulse must be the next expected grant.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_n_en = int'(ref_en) + int'(wr_en) + int'(rd_en);
            if (mon_n_en != 0) begin
                mon_code = ref_en ? G_REF : (wr_en ? G_WR : G_RD);
                chk("en_onehot", 32'(mon_n_en), 32'd1);
                chk("en_single_cycle", 32'(mon_prev), 32'd0);
                if (sb.size() == 0)
                    chk("unexpected_grant", 32'(mon_code), 32'd99);
                else begin
                    exp_g = sb.pop_front();
                    chk("grant_order", 32'(mon_code), 32'(exp_g));
                end
            end
            mon_prev = (mon_n_en != 0) ? 1 : 0;
        end else
            mon_prev = 0;
    end

    initial begin
        rst_n = 1'b0; init_end = 1'b0;
        init_cmd = 4'b0001; init_addr = 12'h111;
        ref_rq = 1'b0; ref_end = 1'b0; ref_cmd = 4'b0001; ref_addr = 12'h400;
        wr_rq = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_addr = 12'h5A5; wr_bank = 2'b10;
        rd_rq = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h3C3; rd_bank = 2'b01;
        #2;
        chk_idle("reset");
        chk("reset_bank", 32'(sdram_bank), 32'd0);
        tick; tick;
        rst_n = 1'b1;

        // Init phase: mux passes init bus through for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            init_cmd  = 4'(i) ^ 4'b1000;
            init_addr = 12'(i * 37 + 5);
            #1;
            chk("init_cmd", 32'(sdram_cmd), 32'(init_cmd));
            chk("init_addr", 32'(sdram_addr), 32'(init_addr));
            chk("init_bank", 32'(sdram_bank), 32'd0);
            chk("init_busy", 32'(busy), 32'd0);
            tick;
        end
        init_end = 1'b1;
        tick;
        chk_idle("arbit_entry");
        init_end = 1'b0;
        tick;
        chk_idle("init_end_fall");

        // Refresh beats a simultaneous write; write follows 2 cycles after ref_end.
        ref_rq = 1'b1; wr_rq = 1'b1;
        sb.push_back(G_REF);
        tick;
        chk_grant(G_REF);
        ref_rq = 1'b0;
        tick;
        chk("aref_en_drop", 32'({ref_en, wr_en, rd_en}), 32'd0);
        chk("aref_busy", 32'(busy), 32'd1);
        chk("aref_addr", 32'(sdram_addr), 32'(ref_addr));
        finish_and_grant(G_REF, G_WR, 1);

        // Stray rd_end in WRITE is ignored; then W,R,W,R with both requests held.
        rd_rq = 1'b1;
        tick;
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        chk("stray_busy", 32'(busy), 32'd1);
        chk("stray_cmd", 32'(sdram_cmd), 32'b0100);
        chk("stray_addr", 32'(sdram_addr), 32'(wr_addr));
        chk("stray_ens", 32'({ref_en, wr_en, rd_en}), 32'd0);
        finish_and_grant(G_WR, G_RD, 6);
        finish_and_grant(G_RD, G_WR, 8);
        finish_and_grant(G_WR, G_RD, 8);
        finish_and_grant(G_RD, G_WR, 8);

        // Refresh raised mid-WRITE: no preemption, refresh served ahead of pending read.
        tick; tick;
        ref_rq = 1'b1;
        repeat (3) begin
            tick;
            chk("no_preempt_en", 32'({ref_en, wr_en, rd_en}), 32'd0);
            chk("no_preempt_busy", 32'(busy), 32'd1);
        end
        wr_end = 1'b1;
        tick;
        wr_end = 1'b0;
        chk_idle("post_wr");
        sb.push_back(G_REF);
        tick;
        chk_grant(G_REF);
        ref_rq = 1'b0;
        finish_and_grant(G_REF, G_RD, 3);

        // Asynchronous reset in the middle of READ.
        tick; tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_bank", 32'(sdram_bank), 32'd0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        repeat (3) begin
            chk("reinit_cmd", 32'(sdram_cmd), 32'(init_cmd));
            chk("reinit_busy", 32'(busy), 32'd0);
            chk("reinit_ens", 32'({ref_en, wr_en, rd_en}), 32'd0);
            tick;
        end
        init_end = 1'b1;
        tick;
        chk_idle("rearbit");
        // last_grant back to READ, so write wins the tie again.
        sb.push_back(G_WR);
        tick;
        chk_grant(G_WR);
        wr_rq = 1'b0; rd_rq = 1'b0;
        tick;
        wr_end = 1'b1;
        tick;
        wr_end = 1'b0;
        tick;
        chk_idle("final_idle");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
